mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the CPU fetch path (IF requester) and the
//  load/store path (D requester). Grants the port, drives the memory for a fixed latency,
//  captures read data and returns a one-cycle ack to the winner. Sits between the CPU
//  (PC/IR, ALU result and S2 bus) and the memory array. Lets the design use one memory.
// PARAMETERS
//  AW      32  address width of all address ports
//  LAT     2   memory access cycles per transaction; minimum 1, values <1 behave as 1
//  RR      0   0 = fixed priority, D always beats IF; 1 = round-robin, last owner loses ties
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   asynchronous reset, active-high
//  if_req    in   1   fetch request; held high with stable if_addr until if_ack
//  if_addr   in   AW  fetch address
//  if_ack    out  1   one-cycle pulse: fetch complete, if_rdata valid
//  if_rdata  out  32  fetched word; held until the next IF transaction completes
//  d_req     in   1   data request; held high with stable d_* inputs until d_ack
//  d_we      in   1   1 = store, 0 = load
//  d_addr    in   AW  data address
//  d_wdata   in   32  store data
//  d_ack     out  1   one-cycle pulse: load/store complete
//  d_rdata   out  32  load data; unchanged by stores
//  m_en      out  1   memory enable, high for exactly LAT cycles per transaction
//  m_we      out  1   memory write enable, valid while m_en=1, else 0
//  m_addr    out  AW  memory address, latched at grant
//  m_wdata   out  32  memory write data, latched at grant
//  m_rdata   in   32  memory read data, sampled on the last access edge
//  busy      out  1   1 while state != IDLE
//  owner     out  1   current or last grantee: 0 = IF, 1 = D
// BEHAVIOUR
//  All outputs are registered. Reset sets every output to 0, state to IDLE and the RR pointer
//  to favour D.
//  States:
//   IDLE:   on an edge with any req high, pick the winner, latch addr/we/wdata into m_*,
//           set m_en=1, cnt=LAT-1, owner=winner, go to ACCESS. No req: stay IDLE.
//   ACCESS: if cnt!=0, decrement cnt. If cnt==0, copy m_rdata into the winner's rdata
//           (loads and fetches only), set m_en=0, m_we=0, pulse the winner's ack, go to RESP.
//   RESP:   clear ack, go to IDLE. This is the single turnaround cycle.
//  Timing: ack rises LAT edges after the grant edge. Throughput is one transaction per LAT+2 cycles.
//  Handshake: a requester deasserts req by the edge after its ack. A req still high at that
//   edge counts as a new request.
//  Arbitration: used only in IDLE.
//   RR=0: D wins every tie.
//   RR=1: on a tie the requester that is not owner wins.
//   A single requester always wins.
//  Requests that drop before grant are ignored. Inputs change only at grant, so later changes
//   to req/addr/wdata during ACCESS/RESP have no effect.
//  cnt width is $clog2(LAT+1). No wrap: cnt only counts down from LAT-1 to 0.
//  The losing requester's ack and rdata stay untouched.
//  Reset mid-transaction forces m_en=0 and clears any ack immediately. The transaction is
//   dropped with no ack and no rdata update; normal arbitration resumes after reset releases.
//  Unknown state encodings recover to IDLE.
// TESTING
//  1 Reset: assert rst with reqs high -> all outputs 0 and busy=0; after release, first grant
//    goes to D if both reqs are high.
//  2 Fetch, LAT=2: if_req=1, if_addr=0x10, m_rdata=0xDEADBEEF -> m_en high 2 cycles with
//    m_addr=0x10; if_ack pulses 1 cycle; if_rdata=0xDEADBEEF; d_ack stays 0.
//  3 Tie, RR=0: if_req and d_req high together, d_addr=0x40 load -> D served first, IF served
//    next, acks 4 cycles apart (LAT=2), owner 1 then 0.
//  4 Tie, RR=1: both reqs re-asserted continuously for 4 transactions -> grants D, IF, D, IF.
//  5 Store: d_we=1, d_addr=0x44, d_wdata=0x1234 -> m_we=1 with m_wdata=0x1234 for LAT cycles;
//    d_ack pulses; d_rdata unchanged.
//  6 Reset in ACCESS: assert rst one cycle after the grant -> m_en drops at once, no ack;
//    a following fetch completes normally with correct data.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, response and memory-side signals for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory environment.
interface mem_port_arbiter_if #(
    parameter int AW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [31:0]   if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_ack;
    logic [31:0]   d_rdata;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;

    logic          busy;
    logic          owner;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
        output m_en, m_we, m_addr, m_wdata, busy, owner
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  m_en, m_we, m_addr, m_wdata, busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (IF) and load/store (D) paths.
// One transaction per LAT+2 cycles: grant, LAT access cycles ending in ack, one turnaround.
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int LAT = 2,
    parameter int RR  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);
    localparam int LAT_EFF = (LAT < 1) ? 1 : LAT;
    localparam int CW      = $clog2(LAT_EFF + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT_EFF - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          busy_q, busy_d;
    logic          m_en_q, m_en_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          win_d;

    // owner doubles as the round-robin pointer: on a tie the non-owner wins.
    always_comb begin
        if (bus.if_req && bus.d_req) begin
            win_d = (RR == 0) ? 1'b1 : ~owner_q;
        end else begin
            win_d = bus.d_req;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        m_en_d     = m_en_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    state_d = ACCESS;
                    owner_d = win_d;
                    m_en_d  = 1'b1;
                    cnt_d   = CNT_INIT;
                    if (win_d) begin
                        m_we_d    = bus.d_we;
                        m_addr_d  = bus.d_addr;
                        m_wdata_d = bus.d_wdata;
                    end else begin
                        m_we_d    = 1'b0;
                        m_addr_d  = bus.if_addr;
                        m_wdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    if (!owner_q) begin
                        if_rdata_d = bus.m_rdata;
                    end else if (!m_we_q) begin
                        d_rdata_d = bus.m_rdata;
                    end
                    m_en_d   = 1'b0;
                    m_we_d   = 1'b0;
                    if_ack_d = ~owner_q;
                    d_ack_d  = owner_q;
                    state_d  = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                m_en_d  = 1'b0;
                m_we_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            busy_q     <= 1'b0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.if_ack   = if_ack_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.m_en     = m_en_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a fixed-priority instance (bus_a) and a round-robin instance (bus_b)
// checked cycle by cycle against a transaction-level model of grant order, timing and memory contents.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int LAT = 2;
    localparam int P   = LAT + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter_if #(.AW(AW)) bus_a ();
    mem_port_arbiter_if #(.AW(AW)) bus_b ();

    mem_port_arbiter #(.AW(AW), .LAT(LAT), .RR(0)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mem_port_arbiter #(.AW(AW), .LAT(LAT), .RR(1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Behavioural memory behind bus_a: unwritten words read the background pattern.
    logic [31:0] mem_a [64];
    logic [63:0] mem_v;
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            mem_v <= '0;
        end else if (bus_a.m_en && bus_a.m_we) begin
            mem_a[bus_a.m_addr[7:2]] <= bus_a.m_wdata;
            mem_v[bus_a.m_addr[7:2]] <= 1'b1;
        end
    end
    assign bus_a.m_rdata = mem_v[bus_a.m_addr[7:2]] ? mem_a[bus_a.m_addr[7:2]]
                                                      : pat({24'd0, bus_a.m_addr[7:2], 2'b00});
    assign bus_b.m_rdata = pat({24'd0, bus_b.m_addr[7:2], 2'b00});

    logic [31:0] ref_mem [64];
    logic [31:0] exp_if_rd_a, exp_d_rd_a;
    logic        exp_owner_a;

    // One round on bus_a: the requested transactions are served D first, then IF.
    task automatic run_round(input logic ui, input logic ud, input logic [31:0] ia,
                             input logic dwe, input logic [31:0] da, input logic [31:0] dw);
        logic        is_d [2];
        int          n;
        logic        e_men, e_busy, e_we, e_iack, e_dack;
        logic [31:0] e_addr;
        n = 0;
        if (ud) begin is_d[n] = 1'b1; n++; end
        if (ui) begin is_d[n] = 1'b0; n++; end
        bus_a.if_req  = ui;
        bus_a.if_addr = ia;
        bus_a.d_req   = ud;
        bus_a.d_we    = dwe;
        bus_a.d_addr  = da;
        bus_a.d_wdata = dw;
        for (int c = 1; c <= n * P + 1; c++) begin
            @(posedge clk); #1;
            e_men = 0; e_busy = 0; e_we = 0; e_iack = 0; e_dack = 0; e_addr = '0;
            for (int k = 0; k < n; k++) begin
                if (c >= 1 + k * P && c <= LAT + 1 + k * P) begin
                    e_busy = 1'b1;
                    exp_owner_a = is_d[k];
                end
                if (c >= 1 + k * P && c <= LAT + k * P) begin
                    e_men  = 1'b1;
                    e_we   = is_d[k] && dwe;
                    e_addr = is_d[k] ? da : ia;
                end
                if (c == LAT + 1 + k * P) begin
                    if (is_d[k]) begin
                        e_dack = 1'b1;
                        if (dwe) ref_mem[da[7:2]] = dw;
                        else     exp_d_rd_a = ref_mem[da[7:2]];
                    end else begin
                        e_iack = 1'b1;
                        exp_if_rd_a = ref_mem[ia[7:2]];
                    end
                end
            end
            checks++;
            if (bus_a.m_en !== e_men) begin
                errors++; $display("FAIL m_en c=%0d: got %b want %b", c, bus_a.m_en, e_men);
            end
            checks++;
            if (bus_a.m_we !== e_we) begin
                errors++; $display("FAIL m_we c=%0d: got %b want %b", c, bus_a.m_we, e_we);
            end
            if (e_men) begin
                checks++;
                if (bus_a.m_addr !== e_addr) begin
                    errors++; $display("FAIL m_addr c=%0d: got %h want %h", c, bus_a.m_addr, e_addr);
                end
            end
            if (e_we) begin
                checks++;
                if (bus_a.m_wdata !== dw) begin
                    errors++; $display("FAIL m_wdata c=%0d: got %h want %h", c, bus_a.m_wdata, dw);
                end
            end
            checks++;
            if (bus_a.busy !== e_busy) begin
                errors++; $display("FAIL busy c=%0d: got %b want %b", c, bus_a.busy, e_busy);
            end
            checks++;
            if (bus_a.owner !== exp_owner_a) begin
                errors++; $display("FAIL owner c=%0d: got %b want %b", c, bus_a.owner, exp_owner_a);
            end
            checks++;
            if (bus_a.if_ack !== e_iack) begin
                errors++; $display("FAIL if_ack c=%0d: got %b want %b", c, bus_a.if_ack, e_iack);
            end
            checks++;
            if (bus_a.d_ack !== e_dack) begin
                errors++; $display("FAIL d_ack c=%0d: got %b want %b", c, bus_a.d_ack, e_dack);
            end
            checks++;
            if (bus_a.if_rdata !== exp_if_rd_a) begin
                errors++; $display("FAIL if_rdata c=%0d: got %h want %h", c, bus_a.if_rdata, exp_if_rd_a);
            end
            checks++;
            if (bus_a.d_rdata !== exp_d_rd_a) begin
                errors++; $display("FAIL d_rdata c=%0d: got %h want %h", c, bus_a.d_rdata, exp_d_rd_a);
            end
            if (e_iack) bus_a.if_req = 1'b0;
            if (e_dack) bus_a.d_req  = 1'b0;
        end
        bus_a.if_req = 1'b0;
        bus_a.d_req  = 1'b0;
    endtask

    task automatic test_reset();
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h20;
        bus_a.d_req  = 1'b1; bus_a.d_we = 1'b0; bus_a.d_addr = 32'h40; bus_a.d_wdata = '0;
        bus_b.if_req = 1'b1; bus_b.d_req = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus_a.if_ack, bus_a.d_ack, bus_a.m_en, bus_a.m_we, bus_a.busy, bus_a.owner} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl_a: got %b want 000000",
                {bus_a.if_ack, bus_a.d_ack, bus_a.m_en, bus_a.m_we, bus_a.busy, bus_a.owner});
        end
        checks++;
        if ({bus_a.m_addr, bus_a.m_wdata, bus_a.if_rdata, bus_a.d_rdata} !== 128'b0) begin
            errors++; $display("FAIL reset_data_a: got %h want 0",
                {bus_a.m_addr, bus_a.m_wdata, bus_a.if_rdata, bus_a.d_rdata});
        end
        checks++;
        if ({bus_b.if_ack, bus_b.d_ack, bus_b.m_en, bus_b.m_we, bus_b.busy, bus_b.owner} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl_b: got %b want 000000",
                {bus_b.if_ack, bus_b.d_ack, bus_b.m_en, bus_b.m_we, bus_b.busy, bus_b.owner});
        end
        bus_b.if_req = 1'b0; bus_b.d_req = 1'b0;
        exp_if_rd_a = '0; exp_d_rd_a = '0; exp_owner_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_round(1'b1, 1'b1, 32'h20, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic test_fetch();
        run_round(1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 32'h0);
        checks++;
        if (bus_a.if_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fetch_data: got %h want deadbeef", bus_a.if_rdata);
        end
    endtask

    task automatic test_tie();
        run_round(1'b1, 1'b1, 32'h28, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic test_store();
        run_round(1'b0, 1'b1, 32'h0, 1'b1, 32'h44, 32'h1234);
        run_round(1'b1, 1'b0, 32'h44, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_access();
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h24;
        @(posedge clk); #1;
        checks++;
        if (bus_a.m_en !== 1'b1) begin
            errors++; $display("FAIL rst_acc_grant: got m_en=%b want 1", bus_a.m_en);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus_a.m_en, bus_a.if_ack, bus_a.busy} !== 3'b000) begin
            errors++; $display("FAIL rst_acc_drop: got en/ack/busy=%b want 000",
                {bus_a.m_en, bus_a.if_ack, bus_a.busy});
        end
        exp_if_rd_a = '0; exp_d_rd_a = '0; exp_owner_a = 1'b0;
        bus_a.if_req = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (bus_a.if_ack !== 1'b0 || bus_a.if_rdata !== 32'h0) begin
                errors++; $display("FAIL rst_acc_noack: got ack=%b rdata=%h want 0 0",
                    bus_a.if_ack, bus_a.if_rdata);
            end
        end
        rst = 1'b0;
        run_round(1'b1, 1'b0, 32'h24, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_random();
        logic        ui, ud, dwe;
        logic [31:0] ia, da, dw;
        for (int r = 0; r < 24; r++) begin
            ui  = 1'($urandom_range(0, 1));
            ud  = 1'($urandom_range(0, 1));
            if (!ui && !ud) ud = 1'b1;
            ia  = 32'($urandom_range(0, 63)) << 2;
            da  = 32'($urandom_range(0, 63)) << 2;
            dwe = 1'($urandom_range(0, 1));
            dw  = $urandom;
            run_round(ui, ud, ia, dwe, da, dw);
        end
    endtask

    // Round-robin instance with both requests held for four transactions.
    task automatic test_rr();
        logic        last, win, e_iack, e_dack;
        logic [31:0] e_if_rd, e_d_rd;
        last = 1'b0; e_if_rd = '0; e_d_rd = '0;
        bus_b.if_addr = 32'h80; bus_b.d_addr = 32'h84; bus_b.d_we = 1'b0; bus_b.d_wdata = '0;
        bus_b.if_req = 1'b1; bus_b.d_req = 1'b1;
        for (int c = 1; c <= 4 * P + 1; c++) begin
            @(posedge clk); #1;
            e_iack = 1'b0; e_dack = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (c == LAT + 1 + k * P) begin
                    win = ~last;
                    last = win;
                    if (win) begin e_dack = 1'b1; e_d_rd = pat(32'h84); end
                    else     begin e_iack = 1'b1; e_if_rd = pat(32'h80); end
                    checks++;
                    if (bus_b.owner !== win) begin
                        errors++; $display("FAIL rr_owner k=%0d: got %b want %b", k, bus_b.owner, win);
                    end
                    if (k == 3) begin bus_b.if_req = 1'b0; bus_b.d_req = 1'b0; end
                end
            end
            checks++;
            if ({bus_b.if_ack, bus_b.d_ack} !== {e_iack, e_dack}) begin
                errors++; $display("FAIL rr_ack c=%0d: got %b want %b", c,
                    {bus_b.if_ack, bus_b.d_ack}, {e_iack, e_dack});
            end
            checks++;
            if (bus_b.if_rdata !== e_if_rd || bus_b.d_rdata !== e_d_rd) begin
                errors++; $display("FAIL rr_rdata c=%0d: got %h/%h want %h/%h", c,
                    bus_b.if_rdata, bus_b.d_rdata, e_if_rd, e_d_rd);
            end
        end
        checks++;
        if (bus_b.busy !== 1'b0) begin
            errors++; $display("FAIL rr_idle: got busy=%b want 0", bus_b.busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = pat(32'(i) << 2);
        bus_a.if_req = 1'b0; bus_a.if_addr = '0; bus_a.d_req = 1'b0;
        bus_a.d_we = 1'b0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
        bus_b.if_req = 1'b0; bus_b.if_addr = '0; bus_b.d_req = 1'b0;
        bus_b.d_we = 1'b0; bus_b.d_addr = '0; bus_b.d_wdata = '0;
        exp_if_rd_a = '0; exp_d_rd_a = '0; exp_owner_a = 1'b0;
        mem_clr = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        test_reset();
        test_fetch();
        test_tie();
        test_store();
        test_reset_access();
        test_random();
        test_rr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
